// File: rtl/alu_serial_responder.sv
// Serial three-word request/response ALU: receives DATA(A), DATA(B), CMD(op),
// then answers with status, result MSB and result LSB words after RESP_GAP idle cycles.
module alu_serial_responder #(
  parameter int RESP_GAP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  // state | meaning
  // IDLE  | waiting for first enable_n low sample (bit 9 of word 0)
  // RX    | shifting in the remaining 29 request bits
  // CALC  | evaluate errors/result, load response shift register
  // GAP   | RESP_GAP idle cycles before the response
  // TX    | 30 response bits on dout, dout_valid high
  // DRAIN | wait for enable_n high before accepting a new frame
  typedef enum logic [2:0] {IDLE, RX, CALC, GAP, TX, DRAIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_rx_sr;
  logic [29:0] r_tx_sr;
  logic [4:0]  r_cnt;

  logic [9:0]  w_word0;
  logic [9:0]  w_word1;
  logic [9:0]  w_word2;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [7:0]  w_op;
  logic        w_par_err;
  logic        w_frame_err;
  logic        w_op_ok;
  logic        w_inv_op;
  logic [15:0] w_alu;
  logic [15:0] w_result;
  logic [7:0]  w_status;

  function automatic logic [9:0] mk_word(input logic t, input logic [7:0] b);
    return {t, b, ^{t, b}};
  endfunction

  assign w_word0 = r_rx_sr[29:20];
  assign w_word1 = r_rx_sr[19:10];
  assign w_word2 = r_rx_sr[9:0];
  assign w_a     = w_word0[8:1];
  assign w_b     = w_word1[8:1];
  assign w_op    = w_word2[8:1];

  // A correct word has even overall parity since bit0 is the XOR of bits 9:1.
  assign w_par_err   = (^w_word0) | (^w_word1) | (^w_word2);
  assign w_frame_err = w_word0[9] | w_word1[9] | ~w_word2[9];

  always_comb begin
    w_alu   = 16'h0000;
    w_op_ok = 1'b1;
    case (w_op)
      8'h00:   w_alu = {8'h00, w_a & w_b};
      8'h01:   w_alu = {8'h00, w_a | w_b};
      8'h02:   w_alu = {8'h00, w_a ^ w_b};
      8'h03:   w_alu = {8'h00, w_a} + {8'h00, w_b};
      8'h04:   w_alu = {8'h00, w_a} - {8'h00, w_b};
      8'h05:   w_alu = {8'h00, w_a} * {8'h00, w_b};
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_inv_op = ~w_op_ok & ~w_par_err & ~w_frame_err;
  assign w_result = (w_par_err | w_frame_err | ~w_op_ok) ? 16'h0000 : w_alu;
  assign w_status = {4'b0000, w_frame_err, w_par_err, w_inv_op, 1'b1};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!enable_n) w_next = RX;
      RX:      if (enable_n) w_next = IDLE;
               else if (r_cnt == 5'd0) w_next = CALC;
      CALC:    w_next = GAP;
      GAP:     if (r_cnt == 5'd0) w_next = TX;
      TX:      if (r_cnt == 5'd0) w_next = DRAIN;
      DRAIN:   if (enable_n) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rx_sr <= 30'd0;
      r_tx_sr <= 30'd0;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (!enable_n) begin
            r_rx_sr <= {29'd0, din};
            r_cnt   <= 5'd28;
          end
        end
        RX: begin
          if (!enable_n) begin
            r_rx_sr <= {r_rx_sr[28:0], din};
            if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
          end
        end
        CALC: begin
          r_tx_sr <= {mk_word(1'b1, w_status),
                      mk_word(1'b0, w_result[15:8]),
                      mk_word(1'b0, w_result[7:0])};
          r_cnt   <= 5'(RESP_GAP - 1);
        end
        GAP: begin
          if (r_cnt == 5'd0) r_cnt <= 5'd29;
          else               r_cnt <= r_cnt - 5'd1;
        end
        TX: begin
          r_tx_sr <= {r_tx_sr[28:0], 1'b0};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign dout_valid = (r_state == TX);
  assign dout       = (r_state == TX) & r_tx_sr[29];

endmodule
